fila_instrucoes: RTL



---
 rtl/fila_pkg.sv | 18 +
 rtl/fila_mem.sv | 25 ++
 rtl/fila_instrucoes.sv | 119 +++++++++++
 3 files changed

// File: rtl/fila_pkg.sv
// Shared constants for the instruction queue; the HALT opcode is also used by
// the BIOS/memory selector.
package fila_pkg;

    localparam logic [5:0]  OPC_HALT  = 6'b111111;
    localparam int          OPC_MSB   = 31;
    localparam int          OPC_LSB   = 26;
    localparam logic [31:0] INSTR_NOP = 32'h00000000;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    function automatic logic is_halt(input logic [31:0] instr);
        opcode_t opc;
        opc = instr[OPC_MSB:OPC_LSB];
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/fila_mem.sv
// Entry storage for the instruction queue: one synchronous write port and one
// asynchronous read port. Contents are not reset; occupancy lives in the parent.
module fila_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fila_instrucoes.sv
// Instruction prefetch queue between the BIOS/memory selector and decode.
// Optional same-cycle bypass into an empty queue: define FILA_BYPASS_EN.
module fila_instrucoes
    import fila_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic [ADDR_W-1:0]          in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halt_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = DATA_W + ADDR_W;

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [ENT_W-1:0]  rdata;
    logic [DATA_W-1:0] head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic              stored_valid;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              push_store;
    logic              pop_store;

    // in_ready looks only at registered state so a full queue never accepts,
    // even when decode drains an entry in the same cycle.
    assign in_ready     = (count != CNT_W'(DEPTH)) && !halt_pending;
    assign stored_valid = (count != '0);
    assign push         = in_valid & in_ready;

`ifdef FILA_BYPASS_EN
    assign bypass = (count == '0) & push;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = stored_valid | bypass;
    assign pop       = out_valid & out_ready;

    // A bypassed word taken by decode never touches storage or occupancy.
    assign push_store = push & ~(bypass & out_ready);
    assign pop_store  = pop & ~bypass;

    assign {head_instr, head_pc} = rdata;

    always_comb begin
        out_instr = DATA_W'(INSTR_NOP);
        out_pc    = '0;
        if (bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (stored_valid) begin
            out_instr = head_instr;
            out_pc    = head_pc;
        end
    end

    fila_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_store & ~flush),
        .waddr (wptr),
        .wdata ({in_instr, in_pc}),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Flush wins over any handshake so nothing fetched before a mode switch survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
        end else if (flush) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
        end else begin
            if (push_store) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_store) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_store, pop_store})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // in_ready is low while a HALT is resident, so set and clear never coincide.
            if (pop_store && is_halt(head_instr[31:0])) begin
                halt_pending <= 1'b0;
            end else if (push_store && is_halt(in_instr[31:0])) begin
                halt_pending <= 1'b1;
            end
        end
    end

endmodule
